// File: rtl/roberto_cmd_rx.sv
// ---------------------------------------------------------------------------
// roberto_cmd_rx
//
// Receive-side command unit for the host serial link. Consumes bytes from the
// UART receiver, frames and validates command packets and issues game-start,
// game-reset and servo-position commands to the rest of the system.
//
// Packet: 0x23 '#', CMD, ARG, [CHK], 0x0A
//   'J' (0x4A) -> jogar pulse          (ARG ignored)
//   'R' (0x52) -> zera_jogo pulse      (ARG ignored)
//   'S' (0x53) -> servo_sel <= ARG[7:6], servo_pos <= ARG[POS_W-1:0],
//                 carrega_servo pulse
//
// Build option:
//   CMD_CHECKSUM_EN  when defined, packets carry a CHK byte that must equal
//                    CMD ^ ARG. When undefined, packets are 4 bytes long and
//                    the esp_chk state is unreachable.
//
// Parameters:
//   TIMEOUT  max clock cycles allowed between bytes inside a packet
//   POS_W    width of the servo position field
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   pronto_rx      one-cycle strobe, dado_rx valid this cycle
//   dado_rx[7:0]   received byte
//   jogar          one-cycle pulse: start game
//   zera_jogo      one-cycle pulse: reset game
//   carrega_servo  one-cycle pulse: servo_sel/servo_pos updated and valid
//   servo_sel[1:0] servo index, held until the next 'S' command
//   servo_pos      servo position, held until the next 'S' command
//   erro           one-cycle pulse: packet rejected
//   db_estado[3:0] debug encoding of the current state
// ---------------------------------------------------------------------------
module roberto_cmd_rx #(
  parameter int TIMEOUT = 50000000,
  parameter int POS_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pronto_rx,
  input  logic [7:0]       dado_rx,
  output logic             jogar,
  output logic             zera_jogo,
  output logic             carrega_servo,
  output logic [1:0]       servo_sel,
  output logic [POS_W-1:0] servo_pos,
  output logic             erro,
  output logic [3:0]       db_estado
);

  // -------------------------------------------------------------------------
  // Protocol constants
  // -------------------------------------------------------------------------
  localparam logic [7:0] BYTE_SOF = 8'h23;  // '#'
  localparam logic [7:0] BYTE_EOF = 8'h0A;  // line feed
  localparam logic [7:0] CMD_J    = 8'h4A;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_S    = 8'h53;

  // Inter-byte counter sizing; the counter saturates at all-ones.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // -------------------------------------------------------------------------
  // State encoding doubles as the db_estado debug value.
  // -------------------------------------------------------------------------
  typedef enum logic [3:0] {
    INICIAL  = 4'b0000,
    ESP_CMD  = 4'b0001,
    ESP_ARG  = 4'b0010,
    ESP_CHK  = 4'b0011,
    ESP_FIM  = 4'b0100,
    EXECUTA  = 4'b0101,
    EST_ERRO = 4'b0110
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       cmd_reg;
  logic [7:0]       arg_reg;
  logic [1:0]       servo_sel_reg;
  logic [POS_W-1:0] servo_pos_reg;

  logic             waiting;      // inside a packet, waiting for a byte
  logic             timeout_hit;  // no byte for TIMEOUT cycles
  logic             cmd_ok;
  logic             chk_ok;
  logic             load_servo;

`ifdef CMD_CHECKSUM_EN
  logic [7:0]       chk_reg;
  assign chk_ok = (chk_reg == (cmd_reg ^ arg_reg));
`else
  assign chk_ok = 1'b1;
`endif

  assign cmd_ok = (cmd_reg == CMD_J) || (cmd_reg == CMD_R) || (cmd_reg == CMD_S);

  assign waiting = (state_reg == ESP_CMD) || (state_reg == ESP_ARG) ||
                   (state_reg == ESP_CHK) || (state_reg == ESP_FIM);

  // A byte arriving in the same cycle as the last allowed count wins, because
  // every waiting state tests pronto_rx before timeout_hit.
  assign timeout_hit = (cnt_reg >= CNT_LAST);

  // Servo registers load on the terminator edge so their new value is already
  // visible during the carrega_servo pulse in executa.
  assign load_servo = (state_reg == ESP_FIM) && pronto_rx &&
                      (dado_rx == BYTE_EOF) && (cmd_reg == CMD_S) && chk_ok;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= INICIAL;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and Moore output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    jogar         = 1'b0;
    zera_jogo     = 1'b0;
    carrega_servo = 1'b0;
    erro          = 1'b0;
    db_estado     = 4'b1111;

    case (state_reg)
      INICIAL: begin
        db_estado = 4'b0000;
        // Anything other than the start byte is dropped silently.
        if (pronto_rx && (dado_rx == BYTE_SOF)) begin
          state_next = ESP_CMD;
        end
      end

      ESP_CMD: begin
        db_estado = 4'b0001;
        // A '#' here is plain data; a misframed packet is caught at the end.
        if (pronto_rx) begin
          state_next = ESP_ARG;
        end else if (timeout_hit) begin
          state_next = EST_ERRO;
        end
      end

      ESP_ARG: begin
        db_estado = 4'b0010;
        if (pronto_rx) begin
`ifdef CMD_CHECKSUM_EN
          state_next = ESP_CHK;
`else
          state_next = ESP_FIM;
`endif
        end else if (timeout_hit) begin
          state_next = EST_ERRO;
        end
      end

`ifdef CMD_CHECKSUM_EN
      ESP_CHK: begin
        db_estado = 4'b0011;
        if (pronto_rx) begin
          state_next = ESP_FIM;
        end else if (timeout_hit) begin
          state_next = EST_ERRO;
        end
      end
`endif

      ESP_FIM: begin
        db_estado = 4'b0100;
        if (pronto_rx) begin
          state_next = (dado_rx == BYTE_EOF) ? EXECUTA : EST_ERRO;
        end else if (timeout_hit) begin
          state_next = EST_ERRO;
        end
      end

      EXECUTA: begin
        db_estado = 4'b0101;
        if (cmd_ok && chk_ok) begin
          jogar         = (cmd_reg == CMD_J);
          zera_jogo     = (cmd_reg == CMD_R);
          carrega_servo = (cmd_reg == CMD_S);
          state_next    = INICIAL;
        end else begin
          state_next = EST_ERRO;
        end
      end

      EST_ERRO: begin
        db_estado  = 4'b0110;
        erro       = 1'b1;
        state_next = INICIAL;
      end

      default: begin
        db_estado  = 4'b1111;
        state_next = INICIAL;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Inter-byte timeout counter: cleared by any byte and outside a packet,
  // counts while waiting, never wraps.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (pronto_rx || !waiting) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Packet field latches and servo output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_reg       <= '0;
      arg_reg       <= '0;
      servo_sel_reg <= '0;
      servo_pos_reg <= '0;
    end else begin
      if ((state_reg == ESP_CMD) && pronto_rx) begin
        cmd_reg <= dado_rx;
      end
      if ((state_reg == ESP_ARG) && pronto_rx) begin
        arg_reg <= dado_rx;
      end
      if (load_servo) begin
        servo_sel_reg <= arg_reg[7:6];
        servo_pos_reg <= arg_reg[POS_W-1:0];
      end
    end
  end

`ifdef CMD_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_reg <= '0;
    end else if ((state_reg == ESP_CHK) && pronto_rx) begin
      chk_reg <= dado_rx;
    end
  end
`endif

  assign servo_sel = servo_sel_reg;
  assign servo_pos = servo_pos_reg;

endmodule

// File: tb/tb_roberto_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_roberto_cmd_rx
//
// Directed bench for roberto_cmd_rx with TIMEOUT = 100. Bytes are strobed on
// pronto_rx roughly every 10 cycles; inputs change on the falling edge and
// outputs are read on the falling edge. Define CMD_CHECKSUM_EN for both the
// bench and the design to exercise the checksum build.
// ---------------------------------------------------------------------------
module tb_roberto_cmd_rx;

  localparam int TIMEOUT = 100;
  localparam int POS_W   = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             pronto_rx;
  logic [7:0]       dado_rx;
  logic             jogar;
  logic             zera_jogo;
  logic             carrega_servo;
  logic [1:0]       servo_sel;
  logic [POS_W-1:0] servo_pos;
  logic             erro;
  logic [3:0]       db_estado;

  always #5 clock = ~clock;

  roberto_cmd_rx #(
    .TIMEOUT (TIMEOUT),
    .POS_W   (POS_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pronto_rx     (pronto_rx),
    .dado_rx       (dado_rx),
    .jogar         (jogar),
    .zera_jogo     (zera_jogo),
    .carrega_servo (carrega_servo),
    .servo_sel     (servo_sel),
    .servo_pos     (servo_pos),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse counters, sampled on the rising edge (values of the cycle ending).
  int jog_cnt   = 0;
  int zer_cnt   = 0;
  int car_cnt   = 0;
  int err_cnt   = 0;
  int multi_cnt = 0;
  int j0, z0, c0, e0;

  always @(posedge clock) begin
    if (jogar === 1'b1)         jog_cnt++;
    if (zera_jogo === 1'b1)     zer_cnt++;
    if (carrega_servo === 1'b1) car_cnt++;
    if (erro === 1'b1)          err_cnt++;
    if ((int'(jogar) + int'(zera_jogo) + int'(carrega_servo) + int'(erro)) > 1)
      multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Called on a falling edge; the byte is accepted on the next rising edge
  // and the task returns on the falling edge right after it.
  task automatic strobe(input logic [7:0] b);
    pronto_rx = 1'b1;
    dado_rx   = b;
    @(negedge clock);
    pronto_rx = 1'b0;
    dado_rx   = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (9) @(negedge clock);
    strobe(b);
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] arg);
    send_byte(8'h23);
    send_byte(cmd);
    send_byte(arg);
`ifdef CMD_CHECKSUM_EN
    send_byte(cmd ^ arg);
`endif
    send_byte(8'h0A);
  endtask

  task automatic snap();
    j0 = jog_cnt;
    z0 = zer_cnt;
    c0 = car_cnt;
    e0 = err_cnt;
  endtask

  task automatic check_counts(input string tag, input int dj, input int dz,
                              input int dc, input int de);
    repeat (3) @(negedge clock);
    check({tag, "_n_jogar"},     jog_cnt - j0, dj);
    check({tag, "_n_zera"},      zer_cnt - z0, dz);
    check({tag, "_n_carrega"},   car_cnt - c0, dc);
    check({tag, "_n_erro"},      err_cnt - e0, de);
  endtask

  initial begin
    reset     = 1'b1;
    pronto_rx = 1'b0;
    dado_rx   = 8'h00;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_db",      db_estado, 4'b0000);
    check("rst_pulses",  {jogar, zera_jogo, carrega_servo, erro}, 4'b0000);
    check("rst_sel",     servo_sel, 2'd0);
    check("rst_pos",     servo_pos, 6'd0);
    reset = 1'b0;
    @(negedge clock);

    // 'J': pulse one cycle after the terminator strobe
    snap();
    send_pkt(8'h4A, 8'h00);
    check("j_pulse",   jogar, 1'b1);
    check("j_db_exec", db_estado, 4'b0101);
    check("j_erro",    erro, 1'b0);
    @(negedge clock);
    check("j_low",     jogar, 1'b0);
    check("j_db_idle", db_estado, 4'b0000);
    check_counts("j", 1, 0, 0, 0);

    // 'S' with ARG 0xC5 -> sel 3, pos 5
    snap();
    send_pkt(8'h53, 8'hC5);
    check("s_pulse", carrega_servo, 1'b1);
    check("s_sel",   servo_sel, 2'd3);
    check("s_pos",   servo_pos, 6'h05);
    check_counts("s", 0, 0, 1, 0);

    // A following 'J' leaves the servo registers alone
    snap();
    send_pkt(8'h4A, 8'h00);
    check("j2_pulse", jogar, 1'b1);
    check("j2_sel",   servo_sel, 2'd3);
    check("j2_pos",   servo_pos, 6'h05);
    check_counts("j2", 1, 0, 0, 0);

    // Unknown command 'X': executa, then erro at N+2, then idle
    snap();
    send_pkt(8'h58, 8'h00);
    check("x_db_exec",  db_estado, 4'b0101);
    check("x_no_erro1", erro, 1'b0);
    @(negedge clock);
    check("x_erro",     erro, 1'b1);
    check("x_db_erro",  db_estado, 4'b0110);
    @(negedge clock);
    check("x_db_idle",  db_estado, 4'b0000);
    check_counts("x", 0, 0, 0, 1);

    // Timeout: 23 52 then silence; erro appears after exactly TIMEOUT cycles
    snap();
    send_byte(8'h23);
    send_byte(8'h52);
    repeat (TIMEOUT - 1) @(negedge clock);
    check("to_db_wait", db_estado, 4'b0010);
    check("to_no_erro", erro, 1'b0);
    @(negedge clock);
    check("to_erro",    erro, 1'b1);
    @(negedge clock);
    check("to_db_idle", db_estado, 4'b0000);
    check_counts("to", 0, 0, 0, 1);

    snap();
    send_pkt(8'h52, 8'h00);
    check("r_pulse", zera_jogo, 1'b1);
    check_counts("r", 0, 1, 0, 0);

    // Byte arriving on the last allowed count wins over the timeout
    snap();
    send_byte(8'h23);
    repeat (TIMEOUT - 1) @(negedge clock);
    strobe(8'h4A);
    check("tw_db_arg", db_estado, 4'b0010);
    send_byte(8'h00);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h4A);
`endif
    send_byte(8'h0A);
    check("tw_pulse", jogar, 1'b1);
    check_counts("tw", 1, 0, 0, 0);

    // Stray bytes in inicial are discarded silently
    snap();
    send_byte(8'h0A);
    send_byte(8'h4A);
    check("stray_db", db_estado, 4'b0000);
    send_pkt(8'h4A, 8'h00);
    check_counts("stray", 1, 0, 0, 0);

`ifdef CMD_CHECKSUM_EN
    // Good checksum: 0x53 ^ 0x41 = 0x12
    snap();
    send_byte(8'h23);
    send_byte(8'h53);
    send_byte(8'h41);
    send_byte(8'h12);
    send_byte(8'h0A);
    check("ck_pulse", carrega_servo, 1'b1);
    check("ck_sel",   servo_sel, 2'd1);
    check("ck_pos",   servo_pos, 6'h01);
    check_counts("ck", 0, 0, 1, 0);

    // Bad checksum: erro, servo unchanged
    snap();
    send_byte(8'h23);
    send_byte(8'h53);
    send_byte(8'h41);
    send_byte(8'h13);
    send_byte(8'h0A);
    @(negedge clock);
    check("bk_erro", erro, 1'b1);
    check_counts("bk", 0, 0, 0, 1);
    check("bk_sel",  servo_sel, 2'd1);
    check("bk_pos",  servo_pos, 6'h01);
`endif

    // Reset mid-packet abandons it; trailing bytes produce nothing
    snap();
    send_byte(8'h23);
    send_byte(8'h4A);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mr_db", db_estado, 4'b0000);
    send_byte(8'h00);
    send_byte(8'h0A);
    check_counts("mr", 0, 0, 0, 0);
    snap();
    send_pkt(8'h4A, 8'h00);
    check("mr_j_pulse", jogar, 1'b1);
    check_counts("mr_j", 1, 0, 0, 0);

    check("onehot", multi_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
